csr_wr_arbiter: RTL

- Shares the single CSR-file write port between NREQ requesters: the retiring CSR FU write, the trap unit (mepc/mcause/mstatus) and the debug/perf path.
- Uses round-robin arbitration into a one-entry registered output stage. The CSR file can stall the write with a busy signal.
- Squashes speculative-source writes on flush.
- Provides a RaW hazard flag so the CSR FU can stall early reads of an address with a pending write.

---
 rtl/csr_wr_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/csr_wr_arbiter.sv
// csr_wr_arbiter: round-robin arbiter sharing the CSR-file write port between
// NREQ requesters, with a one-entry registered output stage, flush squashing
// of speculative sources and a read-after-write hazard flag.
// Optional per-requester stall statistics are built when the macro
// CSR_WR_ARB_STATS_EN is defined (adds stall_cnt_o and starve_o).
module csr_wr_arbiter #(
  parameter int              NREQ       = 3,
  parameter int              XLEN       = 64,
  parameter logic [NREQ-1:0] FLUSH_MASK = 3'b001
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*12-1:0]   req_addr_i,
  input  logic [NREQ*XLEN-1:0] req_wdata_i,
  input  logic                 flush_i,
  input  logic                 csr_wbusy_i,
  output logic                 csr_wvalid_o,
  output logic [11:0]          csr_waddr_o,
  output logic [XLEN-1:0]      csr_wdata_o,
  input  logic [11:0]          raddr_i,
`ifdef CSR_WR_ARB_STATS_EN
  output logic [NREQ*16-1:0]   stall_cnt_o,
  output logic [NREQ-1:0]      starve_o,
`endif
  output logic                 raw_hazard_o
);

  localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Output stage and round-robin pointer
  logic            out_valid_q;
  logic [11:0]     out_addr_q;
  logic [XLEN-1:0] out_data_q;
  logic [SRCW-1:0] out_src_q;
  logic [SRCW-1:0] rr_ptr_q;
  logic [SRCW-1:0] rr_ptr_d;

  logic [NREQ-1:0] elig;
  logic            grant_found;
  logic [SRCW-1:0] grant_idx;
  logic            grant;
  logic            out_flushed;
  logic            can_load;
  logic            retire;
  logic [11:0]     sel_addr;
  logic [XLEN-1:0] sel_data;

  // Output entry is squashed when its source is speculative and flush is high
  assign out_flushed  = out_valid_q && flush_i && FLUSH_MASK[out_src_q];
  assign csr_wvalid_o = out_valid_q && !out_flushed;
  assign csr_waddr_o  = out_addr_q;
  assign csr_wdata_o  = out_data_q;
  assign retire       = csr_wvalid_o && !csr_wbusy_i;
  assign can_load     = !out_valid_q || !csr_wbusy_i || out_flushed;

  // Speculative requesters are not eligible during a flush
  assign elig = req_valid_i & ~({NREQ{flush_i}} & FLUSH_MASK);

  // Round-robin search starting at rr_ptr_q
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && elig[SRCW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = SRCW'(cand);
      end
    end
  end

  // One-hot ready to the winner; ready is held low while in reset
  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready_o[i] = rstn && grant_found && can_load && (grant_idx == SRCW'(i));
    end
  end

  assign grant = rstn && grant_found && can_load;

  // Select winner address and data from the packed request buses
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == SRCW'(i)) begin
        sel_addr = req_addr_i[12*i +: 12];
        sel_data = req_wdata_i[XLEN*i +: XLEN];
      end
    end
  end

  // Pointer moves to the requester after the winner
  always_comb begin
    if (grant_idx == SRCW'(NREQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_idx + SRCW'(1);
    end
  end

  // Output stage: load on grant (drain and load may coincide), clear on retire/flush
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (grant) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= sel_addr;
      out_data_q  <= sel_data;
      out_src_q   <= grant_idx;
      rr_ptr_q    <= rr_ptr_d;
    end else if (retire || out_flushed) begin
      out_valid_q <= 1'b0;
    end
  end

  // RaW hazard: pending output entry or any requesting source hits raddr_i
  always_comb begin
    raw_hazard_o = out_valid_q && (out_addr_q == raddr_i);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid_i[i] && (req_addr_i[12*i +: 12] == raddr_i)) begin
        raw_hazard_o = 1'b1;
      end
    end
  end

`ifdef CSR_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q [NREQ];

  // Saturating count of cycles each requester waits without being accepted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        stall_cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_valid_i[i] && !req_ready_o[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Flatten counters and derive the starvation flags
  always_comb begin
    stall_cnt_o = '0;
    starve_o    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      stall_cnt_o[16*i +: 16] = stall_cnt_q[i];
      starve_o[i]             = (stall_cnt_q[i] >= 16'd64);
    end
  end
`endif

endmodule
